// File: rtl/fir_mac_sequencer_if.sv
// fir_mac_sequencer_if: sample/coefficient/result bus between the FIR sequencer and its surroundings
interface fir_mac_sequencer_if;
    logic               sample_valid;
    logic signed [15:0] sample_in;
    logic signed [15:0] coeff_in;
    logic               sample_ready;
    logic [5:0]         current_count;
    logic signed [15:0] filter_out;
    logic               out_valid;
    logic               busy;
    modport master (
        output sample_valid, sample_in, coeff_in,
        input  sample_ready, current_count, filter_out, out_valid, busy
    );
    modport slave (
        input  sample_valid, sample_in, coeff_in,
        output sample_ready, current_count, filter_out, out_valid, busy
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: 64-tap sequential FIR, one MAC per enabled cycle; define FIR_SATURATE_EN to saturate the output instead of wrapping
module fir_mac_sequencer #(
    parameter int NUM_TAPS = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_enable,
    fir_mac_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
    state_t             state_q, state_d;
    logic [5:0]         count_q, count_d;
    logic signed [39:0] acc_q, acc_d;
    logic signed [15:0] delay_q [NUM_TAPS];
    logic signed [15:0] delay_d [NUM_TAPS];
    logic signed [15:0] filter_out_q, filter_out_d;
    logic               out_valid_q, out_valid_d;
    logic signed [31:0] product;
    logic signed [39:0] shifted;
    logic signed [15:0] result;

    assign bus.sample_ready  = state_q == IDLE;
    assign bus.busy          = state_q != IDLE;
    assign bus.current_count = count_q;
    assign bus.filter_out    = filter_out_q;
    assign bus.out_valid     = out_valid_q;

    // Next-state and datapath; everything but the out_valid pulse holds while clk_enable is low
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        acc_d        = acc_q;
        delay_d      = delay_q;
        filter_out_d = filter_out_q;
        out_valid_d  = 1'b0;
        product      = delay_q[count_q] * bus.coeff_in;
        shifted      = (acc_q + 40'sd16384) >>> 15;
`ifdef FIR_SATURATE_EN
        result = shifted > 40'sd32767 ? 16'sh7fff : shifted < -40'sd32768 ? 16'sh8000 : 16'(shifted);
`else
        result = 16'(shifted);
`endif
        if (clk_enable) begin
            case (state_q)
                IDLE: if (bus.sample_valid) begin
                    for (int k = NUM_TAPS - 1; k > 0; k--) delay_d[k] = delay_q[k - 1];
                    delay_d[0] = bus.sample_in;
                    acc_d      = '0;
                    count_d    = '0;
                    state_d    = MAC;
                end
                MAC: begin
                    acc_d   = acc_q + 40'(product);
                    count_d = count_q + 6'd1;
                    if (count_q == 6'(NUM_TAPS - 1)) begin
                        count_d = '0;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    filter_out_d = result;
                    out_valid_d  = 1'b1;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with asynchronous active-low reset that aborts any frame in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            acc_q        <= '0;
            filter_out_q <= '0;
            out_valid_q  <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) delay_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
            filter_out_q <= filter_out_d;
            out_valid_q  <= out_valid_d;
            delay_q      <= delay_d;
        end
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: randomized and directed checks of fir_mac_sequencer against a sum-of-products model
module tb_fir_mac_sequencer;
    logic clk, rst, clk_enable;
    logic signed [15:0] coeff [64];
    int n_checks = 0;
    int n_pass = 0;

    fir_mac_sequencer_if bus();
    assign bus.coeff_in = coeff[bus.current_count];

    fir_mac_sequencer #(.NUM_TAPS(64)) dut (
        .clk(clk),
        .rst(rst),
        .clk_enable(clk_enable),
        .bus(bus)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit reached");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Behavioural model: the output of a frame is the dot product of the 64 most recent
    // accepted samples with the coefficients, published 65 enabled edges after acceptance
    logic signed [15:0] hist [64];
    bit                 m_busy, m_valid;
    int                 m_left;
    logic signed [15:0] m_out, m_pend;

    function automatic logic signed [15:0] model_out(input logic signed [15:0] s);
        longint acc, r;
        acc = longint'(s) * longint'(coeff[0]);
        for (int k = 1; k < 64; k++) acc += longint'(hist[k - 1]) * longint'(coeff[k]);
        r = (acc + 64'sd16384) >>> 15;
`ifdef FIR_SATURATE_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`endif
        return 16'(r);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 64; k++) hist[k] <= '0;
            m_busy  <= 0;
            m_valid <= 0;
            m_left  <= 0;
            m_out   <= '0;
            m_pend  <= '0;
        end else begin
            m_valid <= 0;
            if (clk_enable) begin
                if (!m_busy && bus.sample_valid) begin
                    for (int k = 1; k < 64; k++) hist[k] <= hist[k - 1];
                    hist[0] <= bus.sample_in;
                    m_pend  <= model_out(bus.sample_in);
                    m_busy  <= 1;
                    m_left  <= 65;
                end else if (m_busy) begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_busy  <= 0;
                        m_valid <= 1;
                        m_out   <= m_pend;
                    end
                end
            end
        end
    end

    // Compare every cycle, mid-period
    always @(negedge clk) begin
        check("sample_ready", int'(bus.sample_ready), int'(!m_busy));
        check("busy", int'(bus.busy), int'(m_busy));
        check("current_count", int'(bus.current_count), m_busy ? (65 - m_left) % 64 : 0);
        check("out_valid", int'(bus.out_valid), int'(m_valid));
        check("filter_out", int'(bus.filter_out), int'(m_out));
    end

    task automatic set_coeffs(input int mode);
        for (int k = 0; k < 64; k++)
            coeff[k] = mode == 0 ? 16'(k == 0 ? 16384 : 0) :
                       mode == 1 ? 16'(k * 256) :
                       mode == 2 ? 16'sd32767 :
                       mode == 3 ? 16'(k == 0 ? 1 : 0) :
                       mode == 4 ? 16'(k == 1 ? 16384 : 0) : 16'($urandom);
    endtask

    task automatic do_reset();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    task automatic send(input logic signed [15:0] s);
        bus.sample_in    = s;
        bus.sample_valid = 1;
        @(negedge clk);
        bus.sample_valid = 0;
    endtask

    task automatic wait_valid(input int stall_at, output int n);
        bit stalled;
        stalled = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (stall_at >= 0 && !stalled && bus.current_count == 6'(stall_at)) begin
                clk_enable = 0;
                repeat (10) begin @(negedge clk); n++; end
                clk_enable = 1;
                stalled = 1;
            end
        end while (!bus.out_valid && n < 300);
        if (!bus.out_valid) check("out_valid_timeout", 0, 1);
    endtask

    task automatic frame(input logic signed [15:0] s, input int stall_at, output int val, output int lat);
        send(s);
        wait_valid(stall_at, lat);
        val = int'(bus.filter_out);
    endtask

    initial begin
        int val, lat, n, pulses;
        rst = 0;
        clk_enable = 1;
        bus.sample_valid = 0;
        bus.sample_in = '0;
        set_coeffs(0);
        repeat (3) @(negedge clk);
        check("reset_ready", int'(bus.sample_ready), 1);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_filter_out", int'(bus.filter_out), 0);
        rst = 1;
        @(negedge clk);

        frame(16'sd16384, -1, val, lat);
        check("single_tap_value", val, 8192);
        check("single_tap_latency", lat, 65);
        @(negedge clk);
        check("single_tap_pulse_width", int'(bus.out_valid), 0);
        check("single_tap_hold", int'(bus.filter_out), 8192);

        do_reset();
        set_coeffs(1);
        for (int i = 0; i < 64; i++) begin
            frame(i == 0 ? 16'sd16384 : 16'sd0, -1, val, lat);
            check($sformatf("impulse_%0d", i), val, i * 128);
        end

        do_reset();
        set_coeffs(2);
        for (int i = 0; i < 64; i++) frame(16'sd32767, -1, val, lat);
`ifdef FIR_SATURATE_EN
        check("overflow_saturate", val, 32767);
`else
        check("overflow_wrap", val, -128);
`endif

        do_reset();
        set_coeffs(3);
        frame(16'sd16384, -1, val, lat);
        check("round_up", val, 1);
        frame(16'sd16383, -1, val, lat);
        check("round_down", val, 0);

        do_reset();
        set_coeffs(0);
        frame(16'sd16384, 30, val, lat);
        check("stall_latency", lat, 75);
        check("stall_value", val, 8192);

        do_reset();
        set_coeffs(4);
        send(16'sd16384);
        repeat (10) @(negedge clk);
        send(16'sd1000);
        wait_valid(-1, lat);
        check("overrun_first_value", int'(bus.filter_out), 0);
        frame(16'sd0, -1, val, lat);
        check("overrun_ignored", val, 8192);

        do_reset();
        set_coeffs(0);
        send(16'sd16384);
        n = 0;
        while (bus.current_count != 6'd30 && n < 100) begin @(negedge clk); n++; end
        check("reach_count_30", int'(bus.current_count), 30);
        rst = 0;
        #1;
        check("midreset_ready", int'(bus.sample_ready), 1);
        check("midreset_busy", int'(bus.busy), 0);
        check("midreset_count", int'(bus.current_count), 0);
        check("midreset_out_valid", int'(bus.out_valid), 0);
        repeat (2) @(negedge clk);
        rst = 1;
        pulses = 0;
        repeat (80) begin @(negedge clk); pulses += int'(bus.out_valid); end
        check("midreset_no_pulse", pulses, 0);
        frame(16'sd16384, -1, val, lat);
        check("midreset_single_tap", val, 8192);

        do_reset();
        set_coeffs(5);
        repeat (4000) begin
            clk_enable = $urandom_range(0, 9) != 0;
            bus.sample_valid = $urandom_range(0, 3) == 0;
            bus.sample_in = 16'($urandom);
            @(negedge clk);
        end
        clk_enable = 1;
        bus.sample_valid = 0;
        repeat (80) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- clk_enable  in  1  global advance enable.
- sample_valid  in  1  new audio sample offered.
- sample_in  in  16  signed Q1.15 audio sample.
- coeff_in  in  16  signed Q1.15 coefficient; the coefficient bank drives it combinationally from current_count in the same cycle.
- sample_ready  out  1  block can accept a sample.
- current_count  out  6  tap index sent to the coefficient bank.
- filter_out  out  16  signed Q1.15 filtered sample.
- out_valid  out  1  one-cycle pulse; filter_out is new.
- busy  out  1  MAC frame in progress; coefficient shadow swap is unsafe.

REQ-002 SHALL have parameter NUM_TAPS, default 64, meaning the number of taps and the delay-line depth; only 64 is supported.

Function
REQ-003 SHALL hold a 64-entry x 16-bit signed delay line, where entry k is the sample k steps old.
REQ-004 SHALL implement the FSM IDLE -> MAC -> DONE -> IDLE; the FSM, counter, accumulator and delay line advance only when clk_enable=1.
REQ-005 In IDLE, SHALL assert sample_ready=1; sample_valid=1 with clk_enable=1 shifts sample_in into entry 0, clears the accumulator and sets current_count=0, then the FSM moves to MAC.
REQ-006 In MAC, SHALL add delay[current_count]*coeff_in (32-bit signed product) to a 40-bit signed accumulator each enabled cycle and increment current_count.
REQ-007 When the MAC step at current_count=63 completes, SHALL go to DONE and wrap current_count to 0.
REQ-008 In DONE, SHALL compute result = (acc + 2^14) >>> 15 (round half up), register it to filter_out, pulse out_valid for exactly one cycle, and return to IDLE.
REQ-009 Latency SHALL be: sample accepted at enabled edge T, out_valid high after enabled edge T+65 (64 MAC cycles plus 1 DONE cycle).
REQ-010 SHALL ignore sample_valid whenever the FSM is not in IDLE (sample_ready=0); no sample is queued.
REQ-011 busy SHALL be 1 in MAC and DONE and 0 in IDLE.
REQ-012 filter_out SHALL hold its last value until the next DONE.
REQ-013 With clk_enable=0, SHALL freeze all state; out_valid SHALL still be a single-cycle pulse and must not stretch.

Reset
REQ-014 When rst=0, SHALL immediately force: FSM=IDLE, current_count=0, accumulator=0, all delay entries=0, filter_out=0, out_valid=0, busy=0, sample_ready=1.
REQ-015 Reset mid-frame SHALL discard the partial frame; no out_valid is produced for it.

Configuration
REQ-016 Macro FIR_SATURATE_EN defined: the rounded result SHALL be saturated to [-32768, 32767].
REQ-017 Macro FIR_SATURATE_EN undefined: filter_out SHALL be the low 16 bits of the rounded result (two's-complement wrap).

Verification
REQ-018 Single tap: coeff[0]=16384, all other coefficients 0, one sample 16384 -> out_valid 65 cycles after acceptance, filter_out=8192.
REQ-019 Impulse response: coeff[k]=k*256, sample 16384 then 63 zeros -> the n-th output is n*128 for n=0..63.
REQ-020 Overflow: all coefficients 32767, 64 samples of 32767 -> filter_out=32767 with FIR_SATURATE_EN; without it, filter_out=0xFF80 (-128).
REQ-021 Rounding: coeff[0]=1, sample 16384 -> filter_out=1; sample 16383 -> filter_out=0.
REQ-022 Stall and overrun:
- clk_enable=0 for 10 cycles at current_count=30 -> out_valid delayed by exactly 10 cycles, value unchanged.
- sample_valid pulsed during MAC -> that sample is ignored and the delay line is unchanged.
REQ-023 Reset mid-frame: rst=0 at current_count=30 -> all outputs take reset values and no out_valid appears; a subsequent single-tap test yields 8192 with no residue from the aborted frame.
